// File: rtl/axi_ad9162_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_ad9162_rx_pkg: shared types/constants for the JESD204 RX deframer   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package axi_ad9162_rx_pkg;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        LOCKED   = 1'b1
    } rx_state_t;

    localparam int c_octet_w  = 8;
    localparam int c_sample_w = 16;
    localparam int c_lane_w   = 32;

    function automatic logic sof_is_onehot(input logic [3:0] sof);
        return (sof != 4'd0) && ((sof & (sof - 4'd1)) == 4'd0);
    endfunction

    // Lowest set bit; only meaningful when sof is one-hot.
    function automatic logic [1:0] sof_index(input logic [3:0] sof);
        logic [1:0] idx;
        idx = 2'd0;
        if (sof[0])      idx = 2'd0;
        else if (sof[1]) idx = 2'd1;
        else if (sof[2]) idx = 2'd2;
        else if (sof[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_ad9162_rx_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_ad9162_rx_lane_align: per-lane frame realignment (prev + 4:1 mux)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi_ad9162_rx_lane_align
    import axi_ad9162_rx_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [1:0]          i_shift,
    input  logic [c_lane_w-1:0] i_cur,
    output logic [c_lane_w-1:0] o_word
);

    logic [c_lane_w-1:0] prev_q;
    logic [c_lane_w-1:0] prev_d;

    always_comb begin
        prev_d = prev_q;
        if (i_load) begin
            prev_d = i_cur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Low word of {cur, prev} >> 8*shift.
    always_comb begin
        o_word = prev_q;
        case (i_shift)
            2'd0:    o_word = prev_q;
            2'd1:    o_word = {i_cur[7:0],  prev_q[31:8]};
            2'd2:    o_word = {i_cur[15:0], prev_q[31:16]};
            2'd3:    o_word = {i_cur[23:0], prev_q[31:24]};
            default: o_word = prev_q;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_ad9162_rx_deframer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_ad9162_rx_deframer: JESD204 RX transport deframer, SOF lock/unpack  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi_ad9162_rx_deframer
    import axi_ad9162_rx_pkg::*;
#(
    parameter int NUM_LANES     = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                      adc_clk,
    input  logic                      adc_rst,
    input  logic                      rx_valid,
    input  logic [NUM_LANES*32-1:0]   rx_data,
    input  logic [3:0]                rx_sof,
    output logic                      rx_ready,
    output logic                      adc_valid,
    output logic [NUM_LANES*32-1:0]   adc_data,
    input  logic                      adc_dovf,
    output logic                      adc_locked,
    output logic [ERR_CNT_WIDTH-1:0]  adc_align_err_count,
    output logic [15:0]               adc_dovf_count
);

    localparam int c_beat_w = NUM_LANES * c_lane_w;

    rx_state_t                state_q, state_d;
    logic [1:0]               shift_q, shift_d;
    logic                     valid_q, valid_d;
    logic [c_beat_w-1:0]      data_q, data_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [15:0]              dovf_cnt_q, dovf_cnt_d;

    logic                     w_load;
    logic                     w_onehot;
    logic [1:0]               w_idx;
    logic [c_lane_w-1:0]      w_aligned [NUM_LANES];
    logic [c_beat_w-1:0]      w_unpacked;

    assign w_onehot = sof_is_onehot(rx_sof);
    assign w_idx    = sof_index(rx_sof);

    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            axi_ad9162_rx_lane_align u_align (
                .clk     (adc_clk),
                .rst     (adc_rst),
                .i_load  (w_load),
                .i_shift (shift_q),
                .i_cur   (rx_data[l*c_lane_w +: c_lane_w]),
                .o_word  (w_aligned[l])
            );

            // Sample k = l + NUM_LANES*j takes aligned octets 2j, 2j+1, MSB first.
            for (genvar j = 0; j < 2; j++) begin : g_unpack
                assign w_unpacked[(l + NUM_LANES*j)*c_sample_w +: c_sample_w] =
                    {w_aligned[l][2*j*c_octet_w +: c_octet_w],
                     w_aligned[l][(2*j+1)*c_octet_w +: c_octet_w]};
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        err_cnt_d  = err_cnt_q;
        dovf_cnt_d = dovf_cnt_q;
        w_load     = 1'b0;

        // Uses the current lock state, so an overflow on a lock-loss edge still counts.
        if (adc_dovf && (state_q == LOCKED) && (dovf_cnt_q != 16'hFFFF)) begin
            dovf_cnt_d = dovf_cnt_q + 16'd1;
        end

        case (state_q)
            WAIT_SOF: begin
                if (rx_valid && w_onehot) begin
                    shift_d = w_idx;
                    w_load  = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (!rx_valid) begin
                    state_d = WAIT_SOF;
                end else if ((rx_sof == 4'd0) || (w_onehot && (w_idx == shift_q))) begin
                    w_load  = 1'b1;
                    valid_d = 1'b1;
                    data_d  = w_unpacked;
                end else begin
                    state_d = WAIT_SOF;
                    if (err_cnt_q != {ERR_CNT_WIDTH{1'b1}}) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            state_q    <= WAIT_SOF;
            shift_q    <= 2'd0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_cnt_q  <= '0;
            dovf_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            err_cnt_q  <= err_cnt_d;
            dovf_cnt_q <= dovf_cnt_d;
        end
    end

    assign rx_ready            = 1'b1;
    assign adc_valid           = valid_q;
    assign adc_data            = data_q;
    assign adc_locked          = (state_q == LOCKED);
    assign adc_align_err_count = err_cnt_q;
    assign adc_dovf_count      = dovf_cnt_q;

endmodule
`default_nettype wire
